// File: rtl/urv_typedef.sv
// Shared memory-bus types for the uRV memory NoC: request/response payloads,
// the 2:1 arbiter state encoding and master identifiers.
package urv_typedef;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        resp_last;
    } mem_resp_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef enum logic {
        MST0,
        MST1
    } noc_mst_id_t;

    function automatic noc_mst_id_t other_mst(input noc_mst_id_t m);
        return (m == MST0) ? MST1 : MST0;
    endfunction

endpackage

// File: rtl/mem_noc_rr_arb2.sv
// Two-way grant selector for the memory NoC arbiter: fixed or round-robin choice,
// plus a grant lock that pins the selection while the presented request is stalled.
import urv_typedef::*;

module mem_noc_rr_arb2 #(
    parameter bit ARB_MODE = 1'b1,
    parameter bit RR_INIT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    input  logic        req1_valid_i,
    input  logic        accept_en_i,
    input  logic        mn_req_ready_i,
    output noc_mst_id_t sel_o
);

    logic        lockVld_q;
    logic        lockVld_d;
    logic        lockSel_q;
    logic        rrLast_q;
    logic        selValid;
    logic        setLock;
    logic        reqHs;
    noc_mst_id_t selComb;

    // A locked grant wins over everything so a stalled request never changes under the router.
    always_comb begin
        selComb = MST0;
        if (lockVld_q) begin
            selComb = noc_mst_id_t'(lockSel_q);
        end else if (req0_valid_i && req1_valid_i) begin
            if (ARB_MODE) begin
                selComb = other_mst(noc_mst_id_t'(rrLast_q));
            end else begin
                selComb = MST0;
            end
        end else if (req1_valid_i) begin
            selComb = MST1;
        end
    end

    assign selValid  = (selComb == MST1) ? req1_valid_i : req0_valid_i;
    assign setLock   = accept_en_i & selValid & ~mn_req_ready_i;
    assign reqHs     = accept_en_i & selValid & mn_req_ready_i;
    assign lockVld_d = reqHs ? 1'b0 : (setLock ? 1'b1 : lockVld_q);
    assign sel_o     = selComb;

    stdffrv #(.W(1), .RV(1'b0)) u_lockVld (
        .clk (clk),
        .rst (rst),
        .d_i (lockVld_d),
        .q_o (lockVld_q)
    );

    stdffrve #(.W(1), .RV(1'b0)) u_lockSel (
        .clk (clk),
        .rst (rst),
        .e_i (setLock),
        .d_i (selComb),
        .q_o (lockSel_q)
    );

    stdffrve #(.W(1), .RV(RR_INIT)) u_rrLast (
        .clk (clk),
        .rst (rst),
        .e_i (reqHs),
        .d_i (selComb),
        .q_o (rrLast_q)
    );

endmodule

// File: rtl/stdffrv.sv
// Library flop: W-bit register with synchronous active-high reset to RV.
module stdffrv #(
    parameter int           W  = 1,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= RV;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/stdffrve.sv
// Library flop: W-bit register with synchronous active-high reset to RV and load enable.
module stdffrve #(
    parameter int           W  = 1,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= RV;
        end else if (e_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/mem_noc_arbiter_2to1.sv
// Merges instruction-fetch (m0) and load/store (m1) masters onto one NoC port,
// one transaction outstanding, responses steered to the owner until resp_last.
import urv_typedef::*;

module mem_noc_arbiter_2to1 #(
    parameter bit ARB_MODE = 1'b1,
    parameter bit RR_INIT  = 1'b1
) (
    input  logic      clk,
    input  logic      rst,

    input  logic      m0_req_valid,
    output logic      m0_req_ready,
    input  mem_req_t  m0_req,
    output logic      m0_resp_valid,
    input  logic      m0_resp_ready,
    output mem_resp_t m0_resp,

    input  logic      m1_req_valid,
    output logic      m1_req_ready,
    input  mem_req_t  m1_req,
    output logic      m1_resp_valid,
    input  logic      m1_resp_ready,
    output mem_resp_t m1_resp,

    output logic      mn_req_valid,
    input  logic      mn_req_ready,
    output mem_req_t  mn_req,
    input  logic      mn_resp_valid,
    output logic      mn_resp_ready,
    input  mem_resp_t mn_resp,

    output logic      arb_busy,
    output logic      arb_owner
);

    arb_state_t  state_q;
    noc_mst_id_t owner_q;
    noc_mst_id_t sel;
    logic        selValid;
    logic        lastHs;
    logic        acceptEn;
    logic        reqHs;

    assign lastHs   = mn_resp_valid & mn_resp_ready & mn_resp.resp_last;
    assign acceptEn = (state_q == ARB_IDLE) | ((state_q == ARB_BUSY) & lastHs);

    mem_noc_rr_arb2 #(
        .ARB_MODE (ARB_MODE),
        .RR_INIT  (RR_INIT)
    ) u_sel (
        .clk            (clk),
        .rst            (rst),
        .req0_valid_i   (m0_req_valid),
        .req1_valid_i   (m1_req_valid),
        .accept_en_i    (acceptEn),
        .mn_req_ready_i (mn_req_ready),
        .sel_o          (sel)
    );

    assign selValid     = (sel == MST1) ? m1_req_valid : m0_req_valid;
    assign mn_req_valid = acceptEn & selValid;
    assign mn_req       = (sel == MST1) ? m1_req : m0_req;
    assign m0_req_ready = acceptEn & mn_req_ready & (sel == MST0);
    assign m1_req_ready = acceptEn & mn_req_ready & (sel == MST1);
    assign reqHs        = mn_req_valid & mn_req_ready;

    // Responses are only accepted while a transaction is outstanding; stray beats back-pressure.
    always_comb begin
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        mn_resp_ready = 1'b0;
        if (state_q == ARB_BUSY) begin
            if (owner_q == MST0) begin
                m0_resp_valid = mn_resp_valid;
                mn_resp_ready = m0_resp_ready;
            end else begin
                m1_resp_valid = mn_resp_valid;
                mn_resp_ready = m1_resp_ready;
            end
        end
    end

    assign m0_resp = mn_resp;
    assign m1_resp = mn_resp;

    // Final beat and a new grant can coincide: the state stays busy and the owner flips.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= MST0;
        end else begin
            case (state_q)
                ARB_IDLE: if (reqHs) state_q <= ARB_BUSY;
                ARB_BUSY: if (lastHs && !reqHs) state_q <= ARB_IDLE;
                default:  state_q <= ARB_IDLE;
            endcase
            if (reqHs) begin
                owner_q <= sel;
            end
        end
    end

    assign arb_busy  = (state_q == ARB_BUSY);
    assign arb_owner = owner_q;

    aReqStable: assert property (@(posedge clk) disable iff (rst)
        (mn_req_valid && !mn_req_ready) |=> $stable(mn_req));
    aOneReqReady: assert property (@(posedge clk) !(m0_req_ready && m1_req_ready));
    aOneRespValid: assert property (@(posedge clk) !(m0_resp_valid && m1_resp_valid));

endmodule

// File: tb/tb_mem_noc_arbiter_2to1.sv
// Directed bench for the 2:1 memory NoC arbiter: a round-robin instance driven by a
// vector table, and a fixed-priority instance sharing the same stimulus.
import urv_typedef::*;

module tb_mem_noc_arbiter_2to1;

    typedef struct {
        bit          pre;
        bit          rst;
        bit          m0v, m1v, mnr, rv, rl, m0rr, m1rr;
        bit          mnv, m0rdy, m1rdy;
        logic [31:0] addr;
        bit          m0rv, m1rv, mnrr, busy, owner;
    } vec_t;

    logic      clk = 1'b0;
    logic      rst;
    logic      m0_req_valid, m1_req_valid, m0_resp_ready, m1_resp_ready;
    logic      mn_req_ready, mn_resp_valid;
    mem_req_t  m0_req, m1_req;
    mem_resp_t mn_resp;

    logic      r_m0_req_ready, r_m1_req_ready, r_m0_resp_valid, r_m1_resp_valid;
    logic      r_mn_req_valid, r_mn_resp_ready, r_arb_busy, r_arb_owner;
    mem_req_t  r_mn_req;
    mem_resp_t r_m0_resp, r_m1_resp;

    logic      f_m0_req_ready, f_m1_req_ready, f_m0_resp_valid, f_m1_resp_valid;
    logic      f_mn_req_valid, f_mn_resp_ready, f_arb_busy, f_arb_owner;
    mem_req_t  f_mn_req;
    mem_resp_t f_m0_resp, f_m1_resp;

    int checks = 0;
    int fails  = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    mem_noc_arbiter_2to1 #(.ARB_MODE(1'b1), .RR_INIT(1'b1)) dutRr (
        .clk (clk), .rst (rst),
        .m0_req_valid (m0_req_valid), .m0_req_ready (r_m0_req_ready), .m0_req (m0_req),
        .m0_resp_valid (r_m0_resp_valid), .m0_resp_ready (m0_resp_ready), .m0_resp (r_m0_resp),
        .m1_req_valid (m1_req_valid), .m1_req_ready (r_m1_req_ready), .m1_req (m1_req),
        .m1_resp_valid (r_m1_resp_valid), .m1_resp_ready (m1_resp_ready), .m1_resp (r_m1_resp),
        .mn_req_valid (r_mn_req_valid), .mn_req_ready (mn_req_ready), .mn_req (r_mn_req),
        .mn_resp_valid (mn_resp_valid), .mn_resp_ready (r_mn_resp_ready), .mn_resp (mn_resp),
        .arb_busy (r_arb_busy), .arb_owner (r_arb_owner)
    );

    mem_noc_arbiter_2to1 #(.ARB_MODE(1'b0), .RR_INIT(1'b1)) dutFix (
        .clk (clk), .rst (rst),
        .m0_req_valid (m0_req_valid), .m0_req_ready (f_m0_req_ready), .m0_req (m0_req),
        .m0_resp_valid (f_m0_resp_valid), .m0_resp_ready (m0_resp_ready), .m0_resp (f_m0_resp),
        .m1_req_valid (m1_req_valid), .m1_req_ready (f_m1_req_ready), .m1_req (m1_req),
        .m1_resp_valid (f_m1_resp_valid), .m1_resp_ready (m1_resp_ready), .m1_resp (f_m1_resp),
        .mn_req_valid (f_mn_req_valid), .mn_req_ready (mn_req_ready), .mn_req (f_mn_req),
        .mn_resp_valid (mn_resp_valid), .mn_resp_ready (f_mn_resp_ready), .mn_resp (mn_resp),
        .arb_busy (f_arb_busy), .arb_owner (f_arb_owner)
    );

    task automatic addVec(input bit pre, input bit rs, input bit [6:0] in, input bit [2:0] rq,
                          input logic [31:0] addr, input bit [4:0] rsp);
        vec_t v;
        v.pre  = pre;    v.rst   = rs;
        v.m0v  = in[6];  v.m1v   = in[5]; v.mnr = in[4]; v.rv = in[3]; v.rl = in[2];
        v.m0rr = in[1];  v.m1rr  = in[0];
        v.mnv  = rq[2];  v.m0rdy = rq[1]; v.m1rdy = rq[0];
        v.addr = addr;
        v.m0rv = rsp[4]; v.m1rv  = rsp[3]; v.mnrr = rsp[2]; v.busy = rsp[1]; v.owner = rsp[0];
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; mn_req_ready = 1'b0;
        mn_resp_valid = 1'b0; mn_resp.resp_last = 1'b0;
        m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst                = v.rst;
        m0_req_valid       = v.m0v;
        m1_req_valid       = v.m1v;
        mn_req_ready       = v.mnr;
        mn_resp_valid      = v.rv;
        mn_resp.resp_last  = v.rl;
        m0_resp_ready      = v.m0rr;
        m1_resp_ready      = v.m1rr;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int row);
        chk("mn_req_valid",  row, 32'(r_mn_req_valid),  32'(v.mnv));
        chk("m0_req_ready",  row, 32'(r_m0_req_ready),  32'(v.m0rdy));
        chk("m1_req_ready",  row, 32'(r_m1_req_ready),  32'(v.m1rdy));
        chk("mn_req.addr",   row, r_mn_req.addr,        v.addr);
        chk("m0_resp_valid", row, 32'(r_m0_resp_valid), 32'(v.m0rv));
        chk("m1_resp_valid", row, 32'(r_m1_resp_valid), 32'(v.m1rv));
        chk("mn_resp_ready", row, 32'(r_mn_resp_ready), 32'(v.mnrr));
        chk("arb_busy",      row, 32'(r_arb_busy),      32'(v.busy));
        chk("arb_owner",     row, 32'(r_arb_owner),     32'(v.owner));
    endtask

    initial begin
        rst = 1'b1;
        m0_req  = '{addr: 32'h0000_0100, we: 1'b0, be: 4'hf, wdata: 32'h0};
        m1_req  = '{addr: 32'h0000_0200, we: 1'b1, be: 4'h3, wdata: 32'hdead_beef};
        mn_resp = '{rdata: 32'h1234_5678, err: 1'b0, resp_last: 1'b0};

        // in = m0v m1v mnr rv rl m0rr m1rr ; req = mnv m0rdy m1rdy ; rsp = m0rv m1rv mnrr busy owner
        // Single 1-beat read by m0
        addVec(1, 0, 7'b0000000, 3'b000, 32'h100, 5'b00000);
        addVec(0, 0, 7'b1010000, 3'b110, 32'h100, 5'b00000);
        addVec(0, 0, 7'b0011110, 3'b010, 32'h100, 5'b10110);
        addVec(0, 0, 7'b0000000, 3'b000, 32'h100, 5'b00000);
        // Contention, round-robin: m0 first, m1 granted on m0's final beat
        addVec(1, 0, 7'b1110000, 3'b110, 32'h100, 5'b00000);
        addVec(0, 0, 7'b0111110, 3'b101, 32'h200, 5'b10110);
        addVec(0, 0, 7'b0000000, 3'b000, 32'h100, 5'b00011);
        addVec(0, 0, 7'b0001101, 3'b000, 32'h100, 5'b01111);
        addVec(0, 0, 7'b0000000, 3'b000, 32'h100, 5'b00001);
        // m1 stalled 3 cycles by the router while m0 arrives: grant stays locked on m1
        addVec(1, 0, 7'b0100000, 3'b100, 32'h200, 5'b00000);
        addVec(0, 0, 7'b1100000, 3'b100, 32'h200, 5'b00000);
        addVec(0, 0, 7'b1100000, 3'b100, 32'h200, 5'b00000);
        addVec(0, 0, 7'b1110000, 3'b101, 32'h200, 5'b00000);
        addVec(0, 0, 7'b1010000, 3'b000, 32'h100, 5'b00011);
        addVec(0, 0, 7'b0011101, 3'b010, 32'h100, 5'b01111);
        // 4-beat response to m0 with toggling ready
        addVec(1, 0, 7'b1010000, 3'b110, 32'h100, 5'b00000);
        addVec(0, 0, 7'b0001011, 3'b000, 32'h100, 5'b10110);
        addVec(0, 0, 7'b0001001, 3'b000, 32'h100, 5'b10010);
        addVec(0, 0, 7'b0001011, 3'b000, 32'h100, 5'b10110);
        addVec(0, 0, 7'b0001001, 3'b000, 32'h100, 5'b10010);
        addVec(0, 0, 7'b0001011, 3'b000, 32'h100, 5'b10110);
        addVec(0, 0, 7'b0001101, 3'b000, 32'h100, 5'b10010);
        addVec(0, 0, 7'b0011111, 3'b010, 32'h100, 5'b10110);
        addVec(0, 0, 7'b0000000, 3'b000, 32'h100, 5'b00000);
        // Reset on beat 2 of 4, then a fresh m1 request while a stray beat is held off
        addVec(1, 0, 7'b1010000, 3'b110, 32'h100, 5'b00000);
        addVec(0, 0, 7'b0001010, 3'b000, 32'h100, 5'b10110);
        addVec(0, 1, 7'b0001010, 3'b000, 32'h100, 5'b10110);
        addVec(0, 0, 7'b0111111, 3'b101, 32'h200, 5'b00000);
        addVec(0, 0, 7'b0000000, 3'b000, 32'h100, 5'b00011);
        addVec(0, 0, 7'b0001101, 3'b000, 32'h100, 5'b01111);
        addVec(0, 0, 7'b0000000, 3'b000, 32'h100, 5'b00001);

        $display("[TB] applying %0d table vectors", vq.size());
        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].pre) doReset();
            applyStimulus(vq[i]);
            checkOutput(vq[i], i);
        end

        // Fixed priority with m0 always requesting: m1 is starved; round-robin instance alternates
        $display("[TB] fixed-priority starvation sequence");
        doReset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            m0_req_valid = 1'b1; m1_req_valid = 1'b1; mn_req_ready = 1'b1;
            mn_resp_valid = 1'b1; mn_resp.resp_last = 1'b1;
            m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
            #1;
            chk("fix m1_req_ready", 100 + c, 32'(f_m1_req_ready), 32'd0);
            chk("fix m0_req_ready", 100 + c, 32'(f_m0_req_ready), 32'd1);
            chk("fix mn_req.addr",  100 + c, f_mn_req.addr, 32'h100);
            if (c == 0) begin
                chk("fix stray mn_resp_ready", 100 + c, 32'(f_mn_resp_ready), 32'd0);
            end else begin
                chk("fix arb_busy",  100 + c, 32'(f_arb_busy),  32'd1);
                chk("fix arb_owner", 100 + c, 32'(f_arb_owner), 32'd0);
                chk("rr arb_owner",  100 + c, 32'(r_arb_owner), 32'((c + 1) % 2));
            end
        end
        doReset();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
